sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares one single-port SRAM macro (512 × 4 × 16-bit words, 1-cycle registered read, `cen`/`wen` control) between one write requester and one read requester. Arbitrates round-robin per cycle, drives SRAM controls combinationally from the grant, and captures read data into a small response FIFO so the read consumer can apply backpressure without losing data. Sits directly in front of the SRAM inside a memory tile; requesters are address generators or streaming ports.

## Interface
- `ADDR_W`, 9, SRAM word address width
- `FETCH_W`, 4, 16-bit lanes per SRAM word
- `DATA_W`, 16, lane width
- `RESP_DEPTH`, 2, response FIFO entries (≥2)

Ports:
- `clk`  in  1  clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `wr_valid`  in  1  write request valid
- `wr_ready`  out  1  write request accepted this cycle
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  FETCH_W×DATA_W  write word, packed [FETCH_W-1:0][DATA_W-1:0]
- `rd_valid`  in  1  read request valid
- `rd_ready`  out  1  read request accepted this cycle
- `rd_addr`  in  ADDR_W  read address
- `resp_valid`  out  1  FIFO head valid
- `resp_ready`  in  1  consumer takes head
- `resp_data`  out  FETCH_W×DATA_W  FIFO head word
- `sram_addr`  out  ADDR_W  to SRAM
- `sram_cen`  out  1  to SRAM
- `sram_wen`  out  1  to SRAM
- `sram_data_in`  out  FETCH_W×DATA_W  to SRAM
- `sram_data_out`  in  FETCH_W×DATA_W  from SRAM, valid 1 cycle after read

## Operation
- Transfer: request fires when valid & ready in the same cycle. Requesters hold valid/addr/data stable until fired.
- `rd_ok` = (fifo_count + inflight − pop) < RESP_DEPTH, where pop = resp_valid & resp_ready, inflight = read issued last cycle.
- Grant: only write valid → write; only read valid & rd_ok → read; both eligible → side indicated by `prio`; read not rd_ok → write if valid, else idle.
- `prio` is a 1-bit round-robin pointer: after a contested grant it points to the loser; uncontested grants leave it unchanged. Resets to read.
- Write grant: `sram_cen`=1, `sram_wen`=1, `sram_addr`=wr_addr, `sram_data_in`=wr_data, `wr_ready`=1.
- Read grant: `sram_cen`=1, `sram_wen`=0, `sram_addr`=rd_addr, `rd_ready`=1; `inflight` set next cycle.
- Idle: `sram_cen`=0, `sram_wen`=0, `sram_addr`=0, `sram_data_in`=0.
- When `inflight`=1, `sram_data_out` is pushed into the FIFO that cycle. Capacity is guaranteed by `rd_ok`; overflow is unreachable (assertion).
- FIFO is show-ahead: `resp_data` = head, `resp_valid` = count≠0. Push and pop in the same cycle are legal at any count, including empty (push-to-empty is visible the following cycle, no bypass).
- Responses are returned in request order. A read issued the cycle after a write to the same address returns the new data.

## Timing
- Reset: `wr_ready`, `rd_ready`, `resp_valid`, `sram_cen`, `sram_wen` = 0. `sram_addr`, `sram_data_in`, `resp_data` = 0. FIFO emptied, `inflight`=0, `prio`=read. Reset mid-read discards the in-flight response.
- `wr_ready`, `rd_ready`, and all SRAM outputs are combinational from current inputs and state. Path resp_ready → rd_ready → sram_cen is accepted.
- Read latency: request fire at cycle t, SRAM data at t+1, `resp_valid` at t+2 earliest.
- With `resp_ready` held high and only reads pending: one read per cycle sustained at RESP_DEPTH=2.
- Write takes effect at the posedge ending the fire cycle.

## Structure
- Package `sram_arb_pkg`: `sram_word_t` (logic [FETCH_W-1:0][DATA_W-1:0]), default ADDR_W/FETCH_W/DATA_W constants, `grant_e` {GNT_IDLE, GNT_WR, GNT_RD}.
- Sub-module `sram_resp_fifo`: parameterised depth, show-ahead, count output. The arbiter and inflight flag live in the top module.
- Bench instantiates a behavioural SRAM model with identical cen/wen/read-latency semantics.

## Test plan
- Write 0xAAAA_BBBB_CCCC_DDDD to addr 5, then read addr 5 → resp_data equals it 2 cycles after rd fire; `sram_wen`=1 only in the write cycle.
- Both valid for 4 cycles, resp_ready=1 → grants alternate RD, WR, RD, WR starting from reset prio=read.
- resp_ready=0, rd_valid held → exactly 2 reads accepted, then rd_ready=0 while writes still granted. Releasing ready drains 2 responses in order, then reads resume.
- Streaming reads addr 0..15, resp_ready=1 → rd_ready high every cycle, responses in address order, no bubbles after fill.
- rst asserted the cycle after a read fire → next cycle resp_valid=0, FIFO empty, SRAM idle, prio=read.
- Write addr 511 then read addr 511 back-to-back → new data returned (address top boundary, no wrap).

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and default geometry for the SRAM port arbiter.
// The defaults describe one 512 x 4 x 16-bit single-port SRAM macro.
package sram_arb_pkg;

    localparam int DEF_ADDR_W  = 9;
    localparam int DEF_FETCH_W = 4;
    localparam int DEF_DATA_W  = 16;

    typedef logic [DEF_FETCH_W-1:0][DEF_DATA_W-1:0] sram_word_t;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_WR,
        GNT_RD
    } grant_e;

endpackage

// File: rtl/sram_resp_fifo.sv
// Show-ahead response FIFO that captures SRAM read data.
// The head is presented without bypass, so a push into an empty FIFO becomes visible one cycle later.
module sram_resp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid  = (count != '0);
    assign do_pop = pop & valid;
    // Gate the head so an empty FIFO shows zero instead of stale storage.
    assign head   = valid ? mem[rd_ptr] : '0;

    // NOTE: storage has no reset; occupancy is tracked by count, so clearing pointers is enough.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !do_pop && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between a write and a read requester,
// with read data captured into a response FIFO so the consumer can stall safely.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FETCH_W    = DEF_FETCH_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RESP_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [FETCH_W-1:0][DATA_W-1:0] wr_data,
    input  logic                           rd_valid,
    output logic                           rd_ready,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [FETCH_W-1:0][DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0]              sram_addr,
    output logic                           sram_cen,
    output logic                           sram_wen,
    output logic [FETCH_W-1:0][DATA_W-1:0] sram_data_in,
    input  logic [FETCH_W-1:0][DATA_W-1:0] sram_data_out
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    grant_e           grant;
    logic             inflight;
    logic             prio_rd;
    logic             pop;
    logic             rd_ok;
    logic             rd_elig;
    logic             contested;
    logic [CNT_W-1:0] fifo_count;

    assign pop = resp_valid & resp_ready;
    // Reserve a FIFO slot for every read still in the SRAM pipeline, crediting a same-cycle pop.
    assign rd_ok     = ({1'b0, fifo_count} + SUM_W'(inflight) - SUM_W'(pop)) < SUM_W'(RESP_DEPTH);
    assign rd_elig   = rd_valid & rd_ok;
    assign contested = wr_valid & rd_elig;

    always_comb begin
        grant = GNT_IDLE;
        if (!rst) begin
            if (contested) begin
                grant = prio_rd ? GNT_RD : GNT_WR;
            end else if (wr_valid) begin
                grant = GNT_WR;
            end else if (rd_elig) begin
                grant = GNT_RD;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        wr_ready     = 1'b0;
        rd_ready     = 1'b0;
        sram_cen     = 1'b0;
        sram_wen     = 1'b0;
        sram_addr    = '0;
        sram_data_in = '0;
        case (grant)
            GNT_WR: begin
                wr_ready     = 1'b1;
                sram_cen     = 1'b1;
                sram_wen     = 1'b1;
                sram_addr    = wr_addr;
                sram_data_in = wr_data;
            end
            GNT_RD: begin
                rd_ready  = 1'b1;
                sram_cen  = 1'b1;
                sram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            prio_rd  <= 1'b1;
        end else begin
            inflight <= (grant == GNT_RD);
            // After a contested grant the pointer moves to the losing side.
            if (contested) begin
                prio_rd <= (grant == GNT_WR);
            end
        end
    end

    sram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (FETCH_W * DATA_W),
        .CNT_W (CNT_W)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (sram_data_out),
        .pop       (pop),
        .head      (resp_data),
        .valid     (resp_valid),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a behavioural SRAM, a shadow memory feeding a
// response scoreboard, and a separate monitor that compares every response the DUT delivers.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AW = DEF_ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  wr_valid, wr_ready;
    logic [AW-1:0]         wr_addr;
    sram_word_t            wr_data;
    logic                  rd_valid, rd_ready;
    logic [AW-1:0]         rd_addr;
    logic                  resp_valid, resp_ready;
    sram_word_t            resp_data;
    logic [AW-1:0]         sram_addr;
    logic                  sram_cen, sram_wen;
    sram_word_t            sram_data_in, sram_data_out;

    sram_word_t            sram_mem [1 << AW];
    sram_word_t            shadow   [1 << AW];
    sram_word_t            sb [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.RESP_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .sram_addr     (sram_addr),
        .sram_cen      (sram_cen),
        .sram_wen      (sram_wen),
        .sram_data_in  (sram_data_in),
        .sram_data_out (sram_data_out)
    );

    // Behavioural single-port SRAM: write on cen&wen, registered 1-cycle read on cen&!wen.
    always @(posedge clk) begin
        if (sram_cen) begin
            if (sram_wen) sram_mem[sram_addr] <= sram_data_in;
            else          sram_data_out <= sram_mem[sram_addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard producer: every fired read pushes the value the shadow memory holds.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (wr_valid && wr_ready) shadow[wr_addr] = wr_data;
            if (rd_valid && rd_ready) sb.push_back(shadow[rd_addr]);
        end
    end

    // Monitor: compares each response the consumer takes against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected: got %h expected no response at %0t", resp_data, $time);
            end else begin
                check("resp_data", resp_data, sb.pop_front());
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [AW-1:0] wa, input sram_word_t wd,
                         input logic rv, input logic [AW-1:0] ra, input logic rr);
        wr_valid   = wv;
        wr_addr    = wa;
        wr_data    = wd;
        rd_valid   = rv;
        rd_addr    = ra;
        resp_ready = rr;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        repeat (n) next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b1, 9'd7, 64'h1, 1'b1, 9'd7, 1'b1);
        next_cycle();
        next_cycle();

        // Reset: requests present but nothing granted, all outputs quiet.
        @(negedge clk);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_cen", sram_cen, 0);
        check("rst_wen", sram_wen, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_din", sram_data_in, 0);
        check("rst_resp_data", resp_data, 0);
        next_cycle();
        rst = 1'b0;
        idle(1);

        // Write then read addr 5.
        drive(1'b1, 9'd5, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("t1_wr_ready", wr_ready, 1);
        check("t1_wr_wen", sram_wen, 1);
        check("t1_wr_cen", sram_cen, 1);
        check("t1_wr_addr", sram_addr, 5);
        check("t1_wr_din", sram_data_in, 64'hAAAA_BBBB_CCCC_DDDD);
        next_cycle();
        drive(1'b0, '0, '0, 1'b1, 9'd5, 1'b1);
        @(negedge clk);
        check("t1_rd_ready", rd_ready, 1);
        check("t1_rd_wen", sram_wen, 0);
        check("t1_rd_addr", sram_addr, 5);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("t1_resp_t1", resp_valid, 0);
        check("t1_idle_cen", sram_cen, 0);
        next_cycle();
        @(negedge clk);
        check("t1_resp_t2", resp_valid, 1);
        check("t1_resp_word", resp_data, 64'hAAAA_BBBB_CCCC_DDDD);
        idle(2);

        // Contention: both valid, grants alternate RD, WR, RD, WR from reset priority.
        drive(1'b1, 9'd10, 64'h1010_2020_3030_4040, 1'b1, 9'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rd_addr = 9'd10;
            @(negedge clk);
            check($sformatf("rr%0d_rd", i), rd_ready, (i % 2 == 0));
            check($sformatf("rr%0d_wr", i), wr_ready, (i % 2 == 1));
            next_cycle();
        end
        idle(4);

        // Preload addresses 0..15.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, AW'(i), {4{16'h1000 + 16'(i)}}, 1'b0, '0, 1'b1);
            @(negedge clk);
            check($sformatf("pre%0d_wr", i), wr_ready, 1);
            next_cycle();
        end
        idle(2);

        // Backpressure: exactly two reads accepted, writes still served, then drain.
        drive(1'b0, '0, '0, 1'b1, 9'd3, 1'b0);
        @(negedge clk);
        check("bp_rd0", rd_ready, 1);
        next_cycle();
        rd_addr = 9'd4;
        @(negedge clk);
        check("bp_rd1", rd_ready, 1);
        next_cycle();
        drive(1'b1, 9'd20, 64'h5555_6666_7777_8888, 1'b1, 9'd5, 1'b0);
        @(negedge clk);
        check("bp_rd_blocked", rd_ready, 0);
        check("bp_wr_granted", wr_ready, 1);
        next_cycle();
        wr_valid = 1'b0;
        @(negedge clk);
        check("bp_rd_blocked2", rd_ready, 0);
        check("bp_full_valid", resp_valid, 1);
        next_cycle();
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_rd_resume", rd_ready, 1);
        next_cycle();
        idle(4);

        // Streaming reads 0..15 with the consumer always ready.
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, '0, '0, (i < 16), AW'(i), 1'b1);
            @(negedge clk);
            if (i < 16) check($sformatf("st%0d_rd", i), rd_ready, 1);
            if (i >= 2) check($sformatf("st%0d_valid", i), resp_valid, 1);
            next_cycle();
        end
        @(negedge clk);
        check("st_end_valid", resp_valid, 0);
        idle(3);

        // Reset right after a read fire; priority must return to read.
        drive(1'b1, 9'd30, 64'h9, 1'b1, 9'd3, 1'b0);
        @(negedge clk);
        check("rs_contest_rd", rd_ready, 1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b1, 9'd4, 1'b0);
        @(negedge clk);
        check("rs_rd_fire", rd_ready, 1);
        next_cycle();
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check("rs_cen_in_rst", sram_cen, 0);
        next_cycle();
        rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("rs_resp_valid", resp_valid, 0);
        check("rs_resp_data", resp_data, 0);
        check("rs_cen_idle", sram_cen, 0);
        next_cycle();
        drive(1'b1, 9'd30, 64'h9, 1'b1, 9'd3, 1'b1);
        @(negedge clk);
        check("rs_prio_rd", rd_ready, 1);
        check("rs_prio_wr", wr_ready, 0);
        check("rs_discarded", resp_valid, 0);
        next_cycle();
        idle(4);

        // Top address write then immediate read.
        drive(1'b1, 9'd511, 64'h0123_4567_89AB_CDEF, 1'b0, '0, 1'b1);
        @(negedge clk);
        check("top_wr_addr", sram_addr, 511);
        next_cycle();
        drive(1'b0, '0, '0, 1'b1, 9'd511, 1'b1);
        @(negedge clk);
        check("top_rd_addr", sram_addr, 511);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
        next_cycle();
        @(negedge clk);
        check("top_resp_word", resp_data, 64'h0123_4567_89AB_CDEF);

        for (int i = 0; i < 20 && sb.size() != 0; i++) next_cycle();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
